// File: rtl/binary_mul_7_arb.sv
// rtl/binary_mul_7_arb.sv - shares one latency-matched 7x7 multiplier among NUM_REQ requesters
// Define BINARY_MUL_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module binary_mul_7_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int LATENCY = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [7*NUM_REQ-1:0] req_a,
  input  logic [7*NUM_REQ-1:0] req_b,
  output logic [6:0]           mul_a,
  output logic [6:0]           mul_b,
  output logic                 mul_en,
  input  logic [13:0]          mul_p,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [13:0]          rsp_p,
  output logic                 busy
);
  logic                      w_found;
  logic [IDW-1:0]            w_gidx;
  logic [NUM_REQ-1:0]        w_ready;
  logic [6:0]                w_sel_a;
  logic [6:0]                w_sel_b;
  logic [6:0]                r_mul_a;
  logic [6:0]                r_mul_b;
  // One extra stage: the multiplier output appears the cycle after its LATENCY-th edge.
  logic [LATENCY:0]          r_tag_v;
  logic [LATENCY:0][IDW-1:0] r_tag_id;

`ifdef BINARY_MUL_ARB_FIXED_PRIO_EN
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_ready = '0;
    w_sel_a = '0;
    w_sel_b = '0;
    if (en && rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && req_valid[i]) begin
          w_found    = 1'b1;
          w_gidx     = IDW'(i);
          w_ready[i] = 1'b1;
          w_sel_a    = req_a[7*i +: 7];
          w_sel_b    = req_b[7*i +: 7];
        end
      end
    end
  end
`else
  logic [IDW-1:0] r_ptr;

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_ready = '0;
    w_sel_a = '0;
    w_sel_b = '0;
    if (en && rst_n) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!w_found && req_valid[i] && (i == (int'(r_ptr) + k) % NUM_REQ)) begin
            w_found    = 1'b1;
            w_gidx     = IDW'(i);
            w_ready[i] = 1'b1;
            w_sel_a    = req_a[7*i +: 7];
            w_sel_b    = req_b[7*i +: 7];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= IDW'(NUM_REQ - 1);
    end else if (en && w_found) begin
      r_ptr <= w_gidx;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_a  <= '0;
      r_mul_b  <= '0;
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else if (en) begin
      if (w_found) begin
        r_mul_a <= w_sel_a;
        r_mul_b <= w_sel_b;
      end
      r_tag_v  <= {r_tag_v[LATENCY-1:0], w_found};
      r_tag_id <= {r_tag_id[LATENCY-1:0], w_gidx};
    end
  end

  assign req_ready = w_ready;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign mul_en    = en;
  assign rsp_valid = r_tag_v[LATENCY];
  assign rsp_id    = r_tag_id[LATENCY];
  assign rsp_p     = mul_p;
  assign busy      = |r_tag_v;
endmodule

// File: tb/tb_binary_mul_7_arb.sv
// tb/tb_binary_mul_7_arb.sv - directed and randomized checks of binary_mul_7_arb with a multiplier model
module tb_binary_mul_7_arb;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int LAT = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [7*N-1:0] req_a = '0;
  logic [7*N-1:0] req_b = '0;
  logic [6:0]     mul_a;
  logic [6:0]     mul_b;
  logic           mul_en;
  logic [13:0]    mul_p;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [13:0]    rsp_p;
  logic           busy;

  always #5 clk = ~clk;

  binary_mul_7_arb #(.NUM_REQ(N), .IDW(IDW), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy)
  );

  // Pipelined multiplier stand-in: product valid LAT edges after A/B change, frozen when en=0.
  logic [13:0] mstage [LAT];
  initial for (int k = 0; k < LAT; k++) mstage[k] = '0;
  always @(posedge clk) begin
    if (mul_en) begin
      for (int k = LAT - 1; k > 0; k--) mstage[k] <= mstage[k-1];
      mstage[0] <= 14'(mul_a) * 14'(mul_b);
    end
  end
  assign mul_p = mstage[LAT-1];

  typedef struct { int id; int p; int rem; } item_t;
  item_t q[$];
  int m_ptr = N - 1;
  int n_vec = 0;
  int n_err = 0;

  function automatic int model_grant();
    if (!en || !rst_n) return -1;
`ifdef BINARY_MUL_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (req_valid[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int g);
    return (g < 0) ? '0 : (N'(1) << g);
  endfunction

  // One clock: model sees the inputs present at the edge; returns at the following negedge.
  task automatic tick();
    int g;
    item_t it;
    g = model_grant();
    @(posedge clk);
    if (rst_n && en) begin
      if (q.size() > 0 && q[0].rem == 0) void'(q.pop_front());
      foreach (q[j]) q[j].rem = q[j].rem - 1;
      if (g >= 0) begin
        it.id  = g;
        it.p   = int'(req_a[7*g +: 7]) * int'(req_b[7*g +: 7]);
        it.rem = LAT;
        q.push_back(it);
        m_ptr = g;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_valid = '0;
    en = 1'b1;
    #1 rst_n = 1'b0;
    q.delete();
    m_ptr = N - 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    n_vec++; if ({mul_a, mul_b} !== '0) begin n_err++; $display("FAIL reset_mul_ab: got %h/%h expected 0/0", mul_a, mul_b); end
    n_vec++; if ({rsp_valid, rsp_id, busy} !== '0) begin n_err++; $display("FAIL reset_rsp: got v=%b id=%0d busy=%b expected 0", rsp_valid, rsp_id, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant: got %b expected 0001", req_ready); end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    req_a[6:0] = 7'd127;
    req_b[6:0] = 7'd127;
    req_valid = 4'b0001;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    for (int k = 1; k < LAT; k++) begin
      tick();
      n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL single_early edge%0d: got v=%b busy=%b expected v=0 busy=1", k + 1, rsp_valid, busy); end
    end
    tick();
    n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 14'd16129) begin n_err++; $display("FAIL single_rsp: got v=%b id=%0d p=%0d expected v=1 id=0 p=16129", rsp_valid, rsp_id, rsp_p); end
    tick();
    n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_after: got v=%b busy=%b expected 0 0", rsp_valid, busy); end
  endtask

`ifndef BINARY_MUL_ARB_FIXED_PRIO_EN
  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[7*i +: 7] = 7'(i + 1);
      req_b[7*i +: 7] = 7'd2;
    end
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_vec++; if (req_ready !== onehot(k % N)) begin n_err++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, onehot(k % N)); end
      tick();
    end
    req_valid = '0;
    for (int j = 0; j < 8; j++) begin
      tick();
      n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(j % N) || rsp_p !== 14'(2 * (j % N + 1))) begin n_err++; $display("FAIL rr_rsp%0d: got v=%b id=%0d p=%0d expected v=1 id=%0d p=%0d", j, rsp_valid, rsp_id, rsp_p, j % N, 2 * (j % N + 1)); end
    end
    tick();
  endtask
`else
  task automatic test_fixed_prio();
    do_reset();
    req_valid = 4'b0011;
    for (int k = 0; k < 10; k++) begin
      #1;
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL fixed_grant%0d: got %b expected 0001", k, req_ready); end
      tick();
    end
    req_valid = '0;
    repeat (LAT + 2) tick();
  endtask
`endif

  task automatic test_en_stall();
    int edges;
    int pulses;
    do_reset();
    req_a[14 +: 7] = 7'd5;
    req_b[14 +: 7] = 7'd6;
    req_valid = 4'b0100;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL stall_grant: got %b expected 0100", req_ready); end
    tick();
    edges = 1;
    req_valid = '0;
    repeat (3) begin tick(); edges++; end
    en = 1'b0;
    req_valid = '1;
    #1;
    n_vec++; if (req_ready !== '0 || mul_en !== 1'b0) begin n_err++; $display("FAIL stall_ready: got ready=%b mul_en=%b expected 0000 0", req_ready, mul_en); end
    repeat (3) begin tick(); edges++; end
    req_valid = '0;
    en = 1'b1;
    while (rsp_valid !== 1'b1 && edges < 20) begin tick(); edges++; end
    n_vec++; if (edges !== 12) begin n_err++; $display("FAIL stall_latency: got %0d edges expected 12", edges); end
    n_vec++; if (rsp_id !== 2'd2 || rsp_p !== 14'd30) begin n_err++; $display("FAIL stall_rsp: got id=%0d p=%0d expected id=2 p=30", rsp_id, rsp_p); end
    pulses = 0;
    repeat (10) begin tick(); if (rsp_valid === 1'b1) pulses++; end
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL stall_dup: got %0d extra pulses expected 0", pulses); end
  endtask

  task automatic test_reset_midflight();
    int seen;
    do_reset();
    req_a[6:0] = 7'd3;  req_b[6:0] = 7'd4;
    req_a[13:7] = 7'd9; req_b[13:7] = 7'd9;
    req_valid = 4'b0011;
    tick();
    tick();
    req_valid = '1;
    tick();
    tick();
    rst_n = 1'b0;
    q.delete();
    m_ptr = N - 1;
    #1;
    n_vec++; if ({rsp_valid, rsp_id, busy, req_ready, mul_a, mul_b} !== '0) begin n_err++; $display("FAIL midreset_outputs: got v=%b id=%0d busy=%b ready=%b a=%0d b=%0d expected all 0", rsp_valid, rsp_id, busy, req_ready, mul_a, mul_b); end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin tick(); if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++; end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL midreset_ghost: got %0d cycles with rsp_valid/busy expected 0", seen); end
    req_valid = '1;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL midreset_first_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    repeat (LAT + 2) tick();
  endtask

  task automatic test_lone();
    int cnt;
    int first;
    int last;
    do_reset();
    req_a[21 +: 7] = 7'd0;
    req_b[21 +: 7] = 7'd100;
    req_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL lone_grant%0d: got %b expected 1000", k, req_ready); end
      tick();
    end
    req_valid = '0;
    cnt = 0; first = -1; last = -1;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (rsp_valid === 1'b1) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
        n_vec++; if (rsp_id !== 2'd3 || rsp_p !== 14'd0) begin n_err++; $display("FAIL lone_rsp: got id=%0d p=%0d expected id=3 p=0", rsp_id, rsp_p); end
      end
    end
    n_vec++; if (cnt !== 5 || last - first !== 4) begin n_err++; $display("FAIL lone_count: got %0d rsps over span %0d expected 5 over 4", cnt, last - first); end
  endtask

  task automatic test_random();
    int g;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      en        = ($urandom_range(0, 9) != 0);
      req_valid = N'($urandom);
      req_a     = (7*N)'($urandom);
      req_b     = (7*N)'($urandom);
      if (c % 37 == 0) req_b[6:0] = 7'd127;
      #1;
      g = model_grant();
      n_vec++; if (req_ready !== onehot(g)) begin n_err++; $display("FAIL rand_grant c%0d: got %b expected %b", c, req_ready, onehot(g)); end
      tick();
      if (q.size() > 0 && q[0].rem == 0) begin
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(q[0].id) || rsp_p !== 14'(q[0].p)) begin n_err++; $display("FAIL rand_rsp c%0d: got v=%b id=%0d p=%0d expected v=1 id=%0d p=%0d", c, rsp_valid, rsp_id, rsp_p, q[0].id, q[0].p); end
      end else begin
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rand_idle c%0d: got rsp_valid=%b expected 0", c, rsp_valid); end
      end
      n_vec++; if (busy !== (q.size() > 0)) begin n_err++; $display("FAIL rand_busy c%0d: got %b expected %b", c, busy, q.size() > 0); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
`ifndef BINARY_MUL_ARB_FIXED_PRIO_EN
    test_round_robin();
`else
    test_fixed_prio();
`endif
    test_en_stall();
    test_reset_midflight();
    test_lone();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/binary_mul_7_arb.md
Name: binary_mul_7_arb

Overview:
Round-robin arbiter and sequencer that shares one Binary_mul_7_1_uni pipelined 7x7 unsigned multiplier (latency 8) between NUM_REQ requesters. It accepts at most one operand pair per cycle via valid/ready and drives the multiplier A/B/en. A tag pipeline matched to the multiplier latency steers each product back with the requester id. Sits between client blocks and the multiplier instance in the datapath top.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDW, 2, requester id width, >= clog2(NUM_REQ)
LATENCY, 8, multiplier latency in clk edges from A/B change to valid P; must match the multiplier

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  global enable; 0 freezes arbiter, tag pipe and multiplier
req_valid  input  NUM_REQ  per-requester operand valid
req_ready  output  NUM_REQ  per-requester grant, one-hot or zero
req_a  input  7*NUM_REQ  packed A operands, requester i at [7i+6:7i]
req_b  input  7*NUM_REQ  packed B operands, same packing
mul_a  output  7  to multiplier A
mul_b  output  7  to multiplier B
mul_en  output  1  to multiplier en
mul_p  input  14  from multiplier P
rsp_valid  output  1  product valid, one cycle per accepted request
rsp_id  output  IDW  requester index owning rsp_p
rsp_p  output  14  product, equals mul_p
busy  output  1  any request in flight

Behaviour:
- Reset (async, rst_n=0): mul_a=0, mul_b=0, all tag stages invalid, rsp_valid=0, rsp_id=0, busy=0, req_ready=0, rr pointer=NUM_REQ-1 so requester 0 wins first. In-flight products are discarded; no rsp_valid for them after reset release.
- mul_en = en, combinational. The multiplier holds its pipeline when en=0.
- Grant (combinational): if en=1, scan requesters from ptr+1 wrapping modulo NUM_REQ; the first with req_valid=1 gets req_ready=1. If en=0 or none are valid, req_ready=0. req_ready may depend on req_valid.
- Handshake: req_valid[i]&req_ready[i] at edge E0. At E0, mul_a/mul_b <= req_a/req_b slice i, tag stage 0 <= {1,i}, ptr <= i. With no handshake and en=1, mul_a/mul_b hold and tag stage 0 <= invalid.
- Tag pipe: LATENCY stages of {valid,id}, shifted only when en=1. rsp_valid = last stage valid; rsp_id = its id; rsp_p = mul_p. Result is present in the cycle after edge E0+LATENCY, i.e. LATENCY+1 edges after handshake when en stays 1. Each en=0 cycle adds one cycle of delay to all in-flight items; none are lost or duplicated.
- Throughput: 1 accept/cycle; back-to-back accepts give back-to-back rsp_valid in the same order.
- No response backpressure. Consumers must take rsp when rsp_valid=1.
- busy = OR of all tag-stage valid bits.
- Arithmetic: unsigned, rsp_p = A*B, range 0..16129; no truncation.
- The rr pointer only moves on a handshake; a lone requester is granted every cycle.

Optional Feature:
BINARY_MUL_ARB_FIXED_PRIO_EN: when defined, the grant is fixed priority with lowest index winning and the rr pointer is removed. When not defined, round-robin as above.

Test Plan:
- Reset, en=1, req0 valid with A=127,B=127 for one handshake -> rsp_valid=1, rsp_id=0, rsp_p=16129 exactly 9 edges after the handshake; busy=1 during that window.
- All 4 requesters valid continuously, A=i+1, B=2 -> grants 0,1,2,3,0...; rsp_id sequence 0,1,2,3 on consecutive cycles, rsp_p=2,4,6,8.
- Handshake req2 A=5,B=6, then en=0 for 3 cycles mid-flight -> rsp_p=30, id=2 arrives 3 cycles later (12 edges); exactly one rsp_valid pulse.
- Two requests in flight, assert rst_n=0 mid-flight -> all outputs 0 immediately, no rsp_valid after release; first grant after release goes to req0.
- Only req3 valid for 5 cycles, A=0,B=100 -> 5 consecutive grants, 5 responses with rsp_p=0, rsp_id=3.
- With BINARY_MUL_ARB_FIXED_PRIO_EN defined, req0 and req1 both continuously valid -> req1 never granted while req0 remains valid.
